// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned MULU/DIVU behind valid/ready.
// Results and flags are registered in DONE and held until consumed; new work may enter on the consume edge.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             op_err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
  logic            zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

  logic            accept, long_op;
  logic [WIDTH-1:0] sum_w, dif_w, sc_res, sc_hi;
  logic            sc_ovf, sc_err;
  logic [WIDTH:0]  mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    sum_w  = a + b;
    dif_w  = a - b;
    case (select)
      OP_ADD: begin
        sc_res = sum_w;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif_w;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MULU: sc_res = '0;
      // Only reached as a single-cycle op when b is zero.
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = a;
        sc_err = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  assign long_op = (select == OP_MULU) || ((select == OP_DIVU) && (b != '0));
  assign accept  = in_valid && in_ready;

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with hi as remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({1'b0, opb_q} & {(WIDTH+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = long_op ? BUSY : DONE;
      BUSY: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? (long_op ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    res_d    = res_q;
    reshi_d  = reshi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (accept) begin
      if (long_op) begin
        cnt_d    = CW'(WIDTH);
        is_div_d = select[0];
        hi_d     = '0;
        lo_d     = a;
        opb_d    = b;
      end else begin
        res_d   = sc_res;
        reshi_d = sc_hi;
        zero_d  = (sc_res == '0);
        ovf_d   = sc_ovf;
        err_d   = sc_err;
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
      if (cnt_q == CW'(1)) begin
        res_d   = step_lo;
        reshi_d = step_hi;
        zero_d  = (step_lo == '0);
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      reshi_q  <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      reshi_q  <= reshi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign result    = res_q;
  assign result_hi = reshi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed literal cases plus randomized ops checked by a queue-based model.
module tb_alu_mc;
  localparam int W = 32;

  logic          clk, reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, result, result_hi;
  logic [3:0]    select;
  logic          zero, ovf, op_err;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .ovf(ovf), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         er;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  bit   seen;
  int   cyc;
  int   checks;
  int   errors;
  bit   rnd_ordy;

  logic [3:0] codes [0:12] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB,
                               4'h8, 4'h9, 4'h8, 4'h9, 4'h1};

  function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, t;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    e.res = '0; e.hi = '0; e.ov = 1'b0; e.er = 1'b0; e.lat = 1; e.acc = 0;
    case (s)
      4'h0: begin t = sx + sy; e.res = t[31:0]; e.ov = (t != longint'($signed(t[31:0]))); end
      4'h2: begin t = sx - sy; e.res = t[31:0]; e.ov = (t != longint'($signed(t[31:0]))); end
      4'h4: e.res = x & y;
      4'h5: e.res = x | y;
      4'h6: e.res = x ^ y;
      4'h7: e.res = ~(x | y);
      4'hA: e.res = (sx < sy) ? 1 : 0;
      4'hB: e.res = (ux < uy) ? 1 : 0;
      4'h8: begin p = ux * uy; e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1; end
      4'h9: begin
        if (y == 0) begin e.res = '1; e.hi = x; e.er = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
      end
      default: e.er = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Compare process: checks every cycle a result is presented, and records acceptances.
  initial begin
    exp_t e;
    cyc = 0; seen = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset_n) begin
        q.delete();
        seen = 0;
        continue;
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 want 0 (no request pending)");
        end else begin
          e = q[0];
          if (!seen) begin
            seen = 1;
            checks++;
            if (cyc - e.acc != e.lat) begin
              errors++;
              $display("FAIL latency: got %0d cycles want %0d", cyc - e.acc, e.lat);
            end
          end
          if (result !== e.res || result_hi !== e.hi || zero !== e.z || ovf !== e.ov || op_err !== e.er) begin
            errors++;
            $display("FAIL out_check: got res=%h hi=%h z=%b ov=%b err=%b want res=%h hi=%h z=%b ov=%b err=%b",
                     result, result_hi, zero, ovf, op_err, e.res, e.hi, e.z, e.ov, e.er);
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(select, a, b);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    in_valid = 1'b1; select = s; a = x; b = y;
    #1;
    while (!in_ready && n < 100) begin
      step();
      #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want acceptance", n);
    end
    @(posedge clk);
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; select = 4'($urandom);
  endtask

  task automatic wait_out(input string name, input int exp_lat);
    int n;
    n = 1;
    #1;
    while (!out_valid && n < 100) begin
      step();
      #1;
      n++;
    end
    chk(name, 64'(n), 64'(exp_lat));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0; rnd_ordy = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; select = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_result", {result_hi, result}, 64'd0);
    chk("reset_flags", {61'd0, zero, ovf, op_err}, 64'd0);
    step();

    out_ready = 1'b1;
    send(4'h0, 32'h7FFF_FFFF, 32'h1);
    wait_out("add_latency", 1);
    chk("add_ovf_result", 64'(result), 64'h8000_0000);
    chk("add_ovf_flags", {61'd0, zero, ovf, op_err}, 64'b010);

    send(4'h2, 32'd5, 32'd5);
    #1;
    chk("sub_zero_result", 64'(result), 64'd0);
    chk("sub_zero_flags", {61'd0, zero, ovf, op_err}, 64'b100);

    send(4'hA, 32'h8000_0000, 32'h7FFF_FFFF);
    #1;
    chk("slt", 64'(result), 64'd1);
    send(4'hB, 32'h8000_0000, 32'h7FFF_FFFF);
    #1;
    chk("sltu", 64'(result), 64'd0);
    step();

    out_ready = 1'b0;
    send(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out("mulu_latency", W + 1);
    chk("mulu_product", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
    repeat (5) step();
    #1;
    chk("mulu_held", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    out_ready = 1'b1;
    send(4'h0, 32'd2, 32'd3);
    #1;
    chk("b2b_add_valid", 64'(out_valid), 64'd1);
    chk("b2b_add_result", 64'(result), 64'd5);
    step();

    send(4'h9, 32'd100, 32'd7);
    wait_out("divu_latency", W + 1);
    chk("divu_qr", {result_hi, result}, {32'd2, 32'd14});
    step();
    send(4'h9, 32'd9, 32'd0);
    wait_out("div0_latency", 1);
    chk("div0_qr", {result_hi, result}, {32'd9, 32'hFFFF_FFFF});
    chk("div0_err", 64'(op_err), 64'd1);
    step();
    send(4'h1, 32'd123, 32'd456);
    #1;
    chk("bad_op", {result_hi, result}, 64'd0);
    chk("bad_op_flags", {61'd0, zero, ovf, op_err}, 64'b101);
    step();

    send(4'h8, 32'd1234, 32'd5678);
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    #1;
    chk("abort_release", {62'd0, out_valid, in_ready}, 64'b01);
    chk("abort_result", {result_hi, result}, 64'd0);
    step();
    send(4'h0, 32'd2, 32'd3);
    #1;
    chk("post_abort_add", 64'(result), 64'd5);
    step();

    rnd_ordy = 1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15)) : codes[$urandom_range(0, 12)];
      repeat ($urandom_range(0, 2)) step();
      send(s, pick(), pick());
    end

    rnd_ordy = 0;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        step();
        n++;
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
    end
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the processor datapath. Single-cycle integer operations keep the existing 4-bit select encoding, and iterative unsigned multiply and divide are added. All ops sit behind a valid/ready handshake, so the control unit can stall on long operations. Results, the zero flag and a signed-overflow flag are registered and held until consumed.

## Interface
- WIDTH, 32, operand/result width (≥4, power of two not required)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- select  in  4  operation code (see Operation)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  primary result (sum, low product, quotient, ...)
- result_hi  out  WIDTH  high product / remainder; 0 for other ops
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- op_err  out  1  unsupported select or divide by zero

## Operation
- Select codes: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1010 SLT (signed), 1011 SLTU, 1000 MULU, 1001 DIVU. All other codes are unsupported.
- Handshake: a request is accepted on a rising edge with in_valid && in_ready. The result is consumed on a rising edge with out_valid && out_ready. Operands and select are sampled only at acceptance.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. A single-cycle op or unsupported code goes to DONE. MULU/DIVU go to BUSY, loading counter=WIDTH.
  - BUSY: one shift-add (MULU) or restoring-subtract (DIVU) step per cycle, counter decrements. Goes to DONE when the step with counter==1 completes.
  - DONE: out_valid=1 and outputs are held stable. On out_ready, returns to IDLE, or accepts a new request in the same cycle (see in_ready).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Width rules:
  - ADD/SUB wrap modulo 2^WIDTH. ovf = operand signs agree (B inverted for SUB) and result sign differs.
  - SLT/SLTU return 1 or 0 zero-extended to WIDTH. SLT uses a true signed compare, not the sign of the difference, so it is correct on overflow.
  - MULU: {result_hi,result} = a*b, full 2*WIDTH-bit unsigned product.
  - DIVU: result = a/b, result_hi = a%b.
- DIVU with b==0: skips BUSY and goes straight to DONE. result=all ones, result_hi=a, op_err=1.
- Unsupported select: result=0, result_hi=0, zero=1, op_err=1.
- zero always reflects the registered result only (not result_hi).

## Timing
- Reset (async assert, sync deassert at the clk edge): state=IDLE, counter=0, out_valid=0, result=0, result_hi=0, zero=0, ovf=0, op_err=0, in_ready=1 once reset_n is high.
- Single-cycle ops: accepted at edge k, out_valid=1 after edge k+1.
- MULU/DIVU: accepted at edge k, out_valid=1 after edge k+WIDTH+1.
- Divide by zero: same latency as a single-cycle op.
- out_valid stays high with all outputs constant until out_ready is sampled high. No result is dropped or overwritten.
- Back-to-back: when out_ready and in_valid are both high in DONE, the old result is consumed and the new op is accepted on the same edge. Single-cycle throughput is then 1 op per cycle.
- in_valid during BUSY is ignored (in_ready=0). The requester must hold the request.
- reset_n low mid-BUSY aborts the op immediately. No partial result is ever presented.

## Test plan
- Reset: hold reset_n=0 mid-MULU, release → out_valid=0, result=0, in_ready=1, next op completes normally.
- ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept.
- SUB 5-5 → result 0, zero=1, ovf=0.
- SLT a=0x80000000, b=0x7FFFFFFF → result 1; SLTU with the same operands → result 0.
- MULU 0xFFFFFFFF*0xFFFFFFFF → result 0x00000001, result_hi 0xFFFFFFFE, out_valid exactly 33 cycles after accept. Hold out_ready=0 for 5 cycles → outputs stable, then back-to-back ADD 2+3 is accepted on the consume edge → result 5 next cycle.
- DIVU 100/7 → result 14, result_hi 2 after 33 cycles. DIVU 9/0 → result 0xFFFFFFFF, result_hi 9, op_err=1 after 1 cycle. select=0001 → result 0, zero=1, op_err=1.
